// File: rtl/nios_debug_host_scan_pkg.sv
// rtl/nios_debug_host_scan_pkg.sv - shared debug package: scan FSM encoding, default widths, slave IR codes
package nios_debug_host_scan_pkg;

  // Default register widths of the Nios debug slave
  localparam int unsigned DEF_DR_WIDTH = 38;
  localparam int unsigned DEF_IR_WIDTH = 2;

  // Virtual IR codes understood by the debug slave
  localparam logic [DEF_IR_WIDTH-1:0] IR_MONITOR = 2'b00;
  localparam logic [DEF_IR_WIDTH-1:0] IR_DEBUG   = 2'b01;
  localparam logic [DEF_IR_WIDTH-1:0] IR_TRACE   = 2'b10;
  localparam logic [DEF_IR_WIDTH-1:0] IR_BYPASS  = 2'b11;

  // Host scan sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_RTI  = 3'd5,
    ST_RSP  = 3'd6
  } scan_state_e;

endpackage

// File: rtl/nios_debug_host_tckgen.sv
// rtl/nios_debug_host_tckgen.sv - tck divider: low then high for TCK_DIV clk each, with edge pulses
module nios_debug_host_tckgen #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tck,
  output logic rise_pulse,
  output logic period_end
);

  localparam int unsigned CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TCK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          phase_q;
  logic          half_end;

  // Pulses are asserted on the clk whose edge flips tck
  assign half_end   = en_i && (cnt_q == CNT_LAST);
  assign rise_pulse = half_end && !phase_q;
  assign period_end = half_end && phase_q;
  assign tck        = phase_q;

  // Half-period counter; disabled means parked at the start of a low phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (half_end) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/nios_debug_host_scan.sv
// rtl/nios_debug_host_scan.sv - virtual-JTAG host: one IR update plus one DR scan per command
module nios_debug_host_scan
  import nios_debug_host_scan_pkg::*;
#(
  parameter int unsigned TCK_DIV  = 2,
  parameter int unsigned DR_WIDTH = DEF_DR_WIDTH,
  parameter int unsigned IR_WIDTH = DEF_IR_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int unsigned BCW = $clog2(DR_WIDTH + 1);

  scan_state_e         state_q, state_d;
  logic                acc_q;
  logic                alive_q;
  logic [IR_WIDTH-1:0] ir_q;
  logic [DR_WIDTH-1:0] sr_q;
  logic [DR_WIDTH-1:0] rsp_q;
  logic [BCW-1:0]      bit_cnt_q;
  logic                tck_en;
  logic                rise_pulse;
  logic                period_end;
  logic                accept;

  nios_debug_host_tckgen #(.TCK_DIV(TCK_DIV)) u_tckgen (
    .clk        (clk),
    .reset      (reset),
    .en_i       (tck_en),
    .tck        (tck),
    .rise_pulse (rise_pulse),
    .period_end (period_end)
  );

  // acc_q keeps IDLE for one extra clk after accept so UIR starts on the following clk
  assign cmd_ready = alive_q && (state_q == ST_IDLE) && !acc_q;
  assign accept    = cmd_valid && cmd_ready;
  assign ir_in     = ir_q;
  assign rsp_dr    = rsp_q;
  assign tdi       = vs_sdr && sr_q[0];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: every scan state lasts whole tck periods
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (acc_q)      state_d = ST_UIR;
      ST_UIR:  if (period_end) state_d = ST_CDR;
      ST_CDR:  if (period_end) state_d = ST_SDR;
      ST_SDR:  if (period_end && (bit_cnt_q == BCW'(DR_WIDTH))) state_d = ST_UDR;
      ST_UDR:  if (period_end) state_d = ST_RTI;
      ST_RTI:  if (period_end) state_d = ST_RSP;
      ST_RSP:  if (rsp_ready)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state only
  always_comb begin
    vs_uir         = 1'b0;
    vs_cdr         = 1'b0;
    vs_sdr         = 1'b0;
    vs_udr         = 1'b0;
    jtag_state_rti = 1'b0;
    rsp_valid      = 1'b0;
    tck_en         = 1'b0;
    case (state_q)
      ST_IDLE: jtag_state_rti = 1'b1;
      ST_UIR:  begin vs_uir = 1'b1;         tck_en = 1'b1; end
      ST_CDR:  begin vs_cdr = 1'b1;         tck_en = 1'b1; end
      ST_SDR:  begin vs_sdr = 1'b1;         tck_en = 1'b1; end
      ST_UDR:  begin vs_udr = 1'b1;         tck_en = 1'b1; end
      ST_RTI:  begin jtag_state_rti = 1'b1; tck_en = 1'b1; end
      ST_RSP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch command, shift on tck rise in SDR, publish response leaving RTI
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q     <= 1'b0;
      alive_q   <= 1'b0;
      ir_q      <= '0;
      sr_q      <= '0;
      rsp_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      alive_q <= 1'b1;
      acc_q   <= accept;
      if (accept) begin
        ir_q      <= cmd_ir;
        sr_q      <= cmd_dr;
        bit_cnt_q <= '0;
      end
      if ((state_q == ST_SDR) && rise_pulse) begin
        sr_q      <= {tdo, sr_q[DR_WIDTH-1:1]};
        bit_cnt_q <= bit_cnt_q + BCW'(1);
      end
      if ((state_q == ST_RTI) && period_end) rsp_q <= sr_q;
    end
  end

endmodule
